multicycle_control: RTL and testbench



---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/multicycle_control_if.sv | 33 +++
 rtl/opcode_class.sv | 22 ++
 rtl/multicycle_control.sv | 121 ++++++++++++
 tb/tb_multicycle_control.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control path: opcodes, ALU function
// codes, FSM state encoding and the opcode-class record.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [3:0] S_IFETCH   = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_EXEC_BR  = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;

  typedef struct packed {
    logic rtype;
    logic imm_alu;
    logic branch;
    logic load;
    logic store;
    logic byte_op;
    logic illegal;
  } op_class_t;

  // lui reuses OR: the decode stage has already shifted Immed into the upper half
  function automatic logic [3:0] imm_alu_func(input logic [5:0] op);
    case (op)
      OP_ANDI:        imm_alu_func = ALU_AND;
      OP_ORI, OP_LUI: imm_alu_func = ALU_OR;
      default:        imm_alu_func = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath-facing control bundle: instruction/status inputs and all stage
// select/enable outputs of the multi-cycle controller.
interface multicycle_control_if #(
  parameter int ALU_FUNC_W = 4
);
  logic [31:0]           Instr;
  logic                  ALU_zero;
  logic                  MEM_ready;
  logic                  IR_LdEn;
  logic                  PC_LdEn;
  logic                  PC_sel;
  logic                  RF_WrEn;
  logic                  RF_WrData_sel;
  logic                  RF_Bsel;
  logic                  ALU_Bin_sel;
  logic [ALU_FUNC_W-1:0] ALU_func;
  logic                  MEM_RdEn;
  logic                  MEM_WrEn;
  logic                  ByteOp;
  logic                  Illegal;

  modport master (
    input  Instr, ALU_zero, MEM_ready,
    output IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_Bsel,
           ALU_Bin_sel, ALU_func, MEM_RdEn, MEM_WrEn, ByteOp, Illegal
  );

  modport slave (
    output Instr, ALU_zero, MEM_ready,
    input  IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_Bsel,
           ALU_Bin_sel, ALU_func, MEM_RdEn, MEM_WrEn, ByteOp, Illegal
  );
endinterface

// File: rtl/opcode_class.sv
// Combinational opcode classifier shared by the DECODE state (live Instr)
// and the later states (registered opcode).
module opcode_class
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  cls
);
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE:                                    cls.rtype   = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LI, OP_LUI:     cls.imm_alu = 1'b1;
      OP_BEQ, OP_BNE, OP_B:                        cls.branch  = 1'b1;
      OP_LB:  begin cls.load  = 1'b1; cls.byte_op = 1'b1; end
      OP_LW:        cls.load  = 1'b1;
      OP_SB:  begin cls.store = 1'b1; cls.byte_op = 1'b1; end
      OP_SW:        cls.store = 1'b1;
      default:                                     cls.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and
// write-back, driving every datapath select/enable from the state register.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int ALU_FUNC_W = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  multicycle_control_if.master bus
);
  logic [3:0] state, state_nxt;
  logic [5:0] op_q;
  logic [3:0] func_q;
  logic       illegal_q;
  op_class_t  dec_cls, q_cls;

  opcode_class u_dec_cls (.op(bus.Instr[31:26]), .cls(dec_cls));
  opcode_class u_q_cls   (.op(op_q),             .cls(q_cls));

  logic unused_bits;
  assign unused_bits = ^{bus.Instr[25:4], q_cls.rtype, q_cls.imm_alu, q_cls.branch,
                         q_cls.store, q_cls.illegal, dec_cls.byte_op};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IFETCH;
      op_q      <= '0;
      func_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        op_q   <= bus.Instr[31:26];
        func_q <= bus.Instr[3:0];
        if (dec_cls.illegal) illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = S_IFETCH;
    case (state)
      S_IFETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_cls.rtype)                       state_nxt = S_EXEC_R;
        else if (dec_cls.imm_alu)                state_nxt = S_EXEC_I;
        else if (dec_cls.branch)                 state_nxt = S_EXEC_BR;
        else if (dec_cls.load || dec_cls.store)  state_nxt = S_MEM_ADDR;
        else                                     state_nxt = S_IFETCH;
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
      S_MEM_ADDR: state_nxt = q_cls.load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = bus.MEM_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_nxt = bus.MEM_ready ? S_IFETCH : S_MEM_WR;
      default:    state_nxt = S_IFETCH;
    endcase
  end

  always_comb begin
    bus.IR_LdEn       = 1'b0;
    bus.PC_LdEn       = 1'b0;
    bus.PC_sel        = 1'b0;
    bus.RF_WrEn       = 1'b0;
    bus.RF_WrData_sel = 1'b0;
    bus.RF_Bsel       = 1'b0;
    bus.ALU_Bin_sel   = 1'b0;
    bus.ALU_func      = '0;
    bus.MEM_RdEn      = 1'b0;
    bus.MEM_WrEn      = 1'b0;
    bus.ByteOp        = 1'b0;
    case (state)
      S_IFETCH: bus.IR_LdEn = 1'b1;
      // DECODE is the only state that looks at the live instruction
      S_DECODE: begin
        bus.RF_Bsel = dec_cls.store | dec_cls.branch;
        bus.PC_LdEn = dec_cls.illegal;
      end
      S_EXEC_R: bus.ALU_func = ALU_FUNC_W'(func_q);
      S_EXEC_I: begin
        bus.ALU_Bin_sel = 1'b1;
        bus.ALU_func    = ALU_FUNC_W'(imm_alu_func(op_q));
      end
      S_EXEC_BR: begin
        bus.RF_Bsel  = 1'b1;
        bus.ALU_func = ALU_FUNC_W'(ALU_SUB);
        bus.PC_LdEn  = 1'b1;
        bus.PC_sel   = (op_q == OP_B) ||
                       ((op_q == OP_BEQ) &&  bus.ALU_zero) ||
                       ((op_q == OP_BNE) && !bus.ALU_zero);
      end
      S_MEM_ADDR: begin
        bus.ALU_Bin_sel = 1'b1;
        bus.ALU_func    = ALU_FUNC_W'(ALU_ADD);
      end
      S_MEM_RD: begin
        bus.MEM_RdEn = 1'b1;
        bus.ByteOp   = q_cls.byte_op;
      end
      S_MEM_WR: begin
        bus.RF_Bsel  = 1'b1;
        bus.MEM_WrEn = 1'b1;
        bus.ByteOp   = q_cls.byte_op;
        bus.PC_LdEn  = bus.MEM_ready;
      end
      S_WB_ALU: begin
        bus.RF_WrEn = 1'b1;
        bus.PC_LdEn = 1'b1;
      end
      S_WB_MEM: begin
        bus.RF_WrEn       = 1'b1;
        bus.RF_WrData_sel = 1'b1;
        bus.PC_LdEn       = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle queues its
// hand-computed output vector; a negedge monitor pops and compares.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if #(.ALU_FUNC_W(4)) bus ();
  multicycle_control #(.ALU_FUNC_W(4)) dut (.Clk(clk), .Reset(rst_n), .bus(bus));

  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   ill_model = 1'b0;

  // {IR,PCld,PCsel,RFwr,WDsel,Bsel,Bin,func[3:0],Rd,Wr,Byte} plus modelled Illegal
  function automatic logic [14:0] o(bit ir, bit pcl, bit pcs, bit rfw, bit wds, bit bsel,
                                     bit bin, logic [3:0] fn, bit rd, bit wr, bit bo);
    return {ir, pcl, pcs, rfw, wds, bsel, bin, fn, rd, wr, bo, ill_model};
  endfunction

  task automatic st(input logic [31:0] ins, input bit z, input bit r, input string nm,
                    input logic [14:0] e);
    exp_t x;
    bus.Instr     = ins;
    bus.ALU_zero  = z;
    bus.MEM_ready = r;
    x.name = nm;
    x.v    = e;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [14:0] act;
    exp_t        x;
    if (sb_q.size() > 0) begin
      x   = sb_q.pop_front();
      act = {bus.IR_LdEn, bus.PC_LdEn, bus.PC_sel, bus.RF_WrEn, bus.RF_WrData_sel,
             bus.RF_Bsel, bus.ALU_Bin_sel, bus.ALU_func, bus.MEM_RdEn, bus.MEM_WrEn,
             bus.ByteOp, bus.Illegal};
      checks++;
      if (act !== x.v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", x.name, act, x.v);
      end
    end
  end

  logic [31:0] A, R, N, U, BQ, BN, BU, LW, LB, SB, SW, IL;
  logic [14:0] IF0, D0;

  initial begin
    A  = 32'hC0220005; R  = 32'h80430803; N  = 32'hC8220001; U  = 32'hE4200010;
    BQ = 32'h00220003; BN = 32'h04220003; BU = 32'hFC000001;
    LW = 32'h3C220004; LB = 32'h0C220000; SB = 32'h1C220000; SW = 32'h7C220000;
    IL = 32'hA8000000;
    rst_n = 1'b0;
    bus.Instr = '0; bus.ALU_zero = 1'b0; bus.MEM_ready = 1'b0;
    @(posedge clk);
    #1;
    IF0 = o(1,0,0,0,0,0,0,4'h0,0,0,0);
    D0  = o(0,0,0,0,0,0,0,4'h0,0,0,0);

    st(32'h0, 0, 1, "rst_a", IF0);
    st(32'h0, 0, 1, "rst_b", IF0);
    rst_n = 1'b1;

    // addi: 4 cycles, MEM_ready ignored outside memory states
    st(A, 0, 1, "addi_if",  IF0);
    st(A, 0, 1, "addi_dec", D0);
    st(A, 0, 1, "addi_ex",  o(0,0,0,0,0,0,1,4'h0,0,0,0));
    st(A, 0, 1, "addi_wb",  o(0,1,0,1,0,0,0,4'h0,0,0,0));
    // R-type, func[3:0]=3
    st(R, 0, 0, "r_if",  IF0);
    st(R, 0, 0, "r_dec", D0);
    st(R, 0, 0, "r_ex",  o(0,0,0,0,0,0,0,4'h3,0,0,0));
    st(R, 0, 0, "r_wb",  o(0,1,0,1,0,0,0,4'h0,0,0,0));
    // andi, lui
    st(N, 0, 0, "andi_if",  IF0);
    st(N, 0, 0, "andi_dec", D0);
    st(N, 0, 0, "andi_ex",  o(0,0,0,0,0,0,1,4'h2,0,0,0));
    st(N, 0, 0, "andi_wb",  o(0,1,0,1,0,0,0,4'h0,0,0,0));
    st(U, 0, 0, "lui_if",   IF0);
    st(U, 0, 0, "lui_dec",  D0);
    st(U, 0, 0, "lui_ex",   o(0,0,0,0,0,0,1,4'h3,0,0,0));
    st(U, 0, 0, "lui_wb",   o(0,1,0,1,0,0,0,4'h0,0,0,0));
    // branches: 3 cycles each
    st(BQ, 1, 0, "beqt_if",  IF0);
    st(BQ, 1, 0, "beqt_dec", o(0,0,0,0,0,1,0,4'h0,0,0,0));
    st(BQ, 1, 0, "beqt_br",  o(0,1,1,0,0,1,0,4'h1,0,0,0));
    st(BQ, 0, 0, "beqn_if",  IF0);
    st(BQ, 0, 0, "beqn_dec", o(0,0,0,0,0,1,0,4'h0,0,0,0));
    st(BQ, 0, 0, "beqn_br",  o(0,1,0,0,0,1,0,4'h1,0,0,0));
    st(BN, 1, 0, "bne_if",   IF0);
    st(BN, 1, 0, "bne_dec",  o(0,0,0,0,0,1,0,4'h0,0,0,0));
    st(BN, 0, 0, "bne_br",   o(0,1,1,0,0,1,0,4'h1,0,0,0));
    st(BN, 1, 0, "bnez_if",  IF0);
    st(BN, 1, 0, "bnez_dec", o(0,0,0,0,0,1,0,4'h0,0,0,0));
    st(BN, 1, 0, "bnez_br",  o(0,1,0,0,0,1,0,4'h1,0,0,0));
    st(BU, 0, 0, "b_if",     IF0);
    st(BU, 0, 0, "b_dec",    o(0,0,0,0,0,1,0,4'h0,0,0,0));
    st(BU, 0, 0, "b_br",     o(0,1,1,0,0,1,0,4'h1,0,0,0));
    // lw with two wait cycles: 7 cycles total
    st(LW, 0, 1, "lw_if",   IF0);
    st(LW, 0, 1, "lw_dec",  D0);
    st(LW, 0, 0, "lw_addr", o(0,0,0,0,0,0,1,4'h0,0,0,0));
    st(LW, 0, 0, "lw_rd0",  o(0,0,0,0,0,0,0,4'h0,1,0,0));
    st(LW, 0, 0, "lw_rd1",  o(0,0,0,0,0,0,0,4'h0,1,0,0));
    st(LW, 0, 1, "lw_rd2",  o(0,0,0,0,0,0,0,4'h0,1,0,0));
    st(LW, 0, 0, "lw_wb",   o(0,1,0,1,1,0,0,4'h0,0,0,0));
    // lb: byte read
    st(LB, 0, 1, "lb_if",   IF0);
    st(LB, 0, 1, "lb_dec",  D0);
    st(LB, 0, 1, "lb_addr", o(0,0,0,0,0,0,1,4'h0,0,0,0));
    st(LB, 0, 1, "lb_rd",   o(0,0,0,0,0,0,0,4'h0,1,0,1));
    st(LB, 0, 1, "lb_wb",   o(0,1,0,1,1,0,0,4'h0,0,0,0));
    // sb with one wait cycle; no RF write anywhere
    st(SB, 0, 1, "sb_if",   IF0);
    st(SB, 0, 1, "sb_dec",  o(0,0,0,0,0,1,0,4'h0,0,0,0));
    st(SB, 0, 1, "sb_addr", o(0,0,0,0,0,0,1,4'h0,0,0,0));
    st(SB, 0, 0, "sb_wr0",  o(0,0,0,0,0,1,0,4'h0,0,1,1));
    st(SB, 0, 1, "sb_wr1",  o(0,1,0,0,0,1,0,4'h0,0,1,1));
    // sw: 4 cycles
    st(SW, 0, 1, "sw_if",   IF0);
    st(SW, 0, 1, "sw_dec",  o(0,0,0,0,0,1,0,4'h0,0,0,0));
    st(SW, 0, 1, "sw_addr", o(0,0,0,0,0,0,1,4'h0,0,0,0));
    st(SW, 0, 1, "sw_wr",   o(0,1,0,0,0,1,0,4'h0,0,1,0));
    // illegal opcode 0x2A: PC_LdEn in DECODE, Illegal sticky afterwards
    st(IL, 0, 1, "ill_if",  IF0);
    st(IL, 0, 1, "ill_dec", o(0,1,0,0,0,0,0,4'h0,0,0,0));
    ill_model = 1'b1;
    st(A, 0, 1, "post_if",  o(1,0,0,0,0,0,0,4'h0,0,0,0));
    st(A, 0, 1, "post_dec", o(0,0,0,0,0,0,0,4'h0,0,0,0));
    st(A, 0, 1, "post_ex",  o(0,0,0,0,0,0,1,4'h0,0,0,0));
    st(A, 0, 1, "post_wb",  o(0,1,0,1,0,0,0,4'h0,0,0,0));
    // reset in the middle of a stalled load
    st(LW, 0, 0, "lw2_if",   o(1,0,0,0,0,0,0,4'h0,0,0,0));
    st(LW, 0, 0, "lw2_dec",  o(0,0,0,0,0,0,0,4'h0,0,0,0));
    st(LW, 0, 0, "lw2_addr", o(0,0,0,0,0,0,1,4'h0,0,0,0));
    st(LW, 0, 0, "lw2_rd",   o(0,0,0,0,0,0,0,4'h0,1,0,0));
    rst_n = 1'b0;
    ill_model = 1'b0;
    st(LW, 0, 1, "rst_mid", o(1,0,0,0,0,0,0,4'h0,0,0,0));
    rst_n = 1'b1;
    st(BQ, 1, 1, "rel_if",  o(1,0,0,0,0,0,0,4'h0,0,0,0));
    st(BQ, 1, 1, "rel_dec", o(0,0,0,0,0,1,0,4'h0,0,0,0));
    st(BQ, 1, 1, "rel_br",  o(0,1,1,0,0,1,0,4'h1,0,0,0));
    st(A, 0, 0, "rel_next", o(1,0,0,0,0,0,0,4'h0,0,0,0));

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
